// File: rtl/nr_fetch_unit.sv
// nr_fetch_unit: instruction fetch stage between the PC logic and the decoder.
// It issues one read per cycle into the instruction memory and queues each returned
// word, tagged with its fetch address, in a small prefetch FIFO. The FIFO head goes
// to decode over a valid/ready handshake. A redirect flushes all queued and
// in-flight words and restarts fetch at the target address.
//
// Ports
//   clk        in   clock, rising edge
//   clr_n      in   asynchronous active-low reset
//   im_rd      out  memory read request (combinational issue decision)
//   im_adr     out  memory read address (current pc)
//   im_data    in   memory read data, valid the cycle after im_rd
//   redir      in   redirect strobe (taken branch/jump)
//   redir_adr  in   redirect target
//   ins_vld    out  FIFO head holds a valid instruction
//   ins        out  FIFO head instruction word
//   ins_pc     out  fetch address of the head word
//   ins_rdy    in   decode accepts the head word
module nr_fetch_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ADR_W = 8,
  parameter int unsigned INS_W = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  output logic             im_rd,
  output logic [ADR_W-1:0] im_adr,
  input  logic [INS_W-1:0] im_data,
  input  logic             redir,
  input  logic [ADR_W-1:0] redir_adr,
  output logic             ins_vld,
  output logic [INS_W-1:0] ins,
  output logic [ADR_W-1:0] ins_pc,
  input  logic             ins_rdy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  // One extra bit so count + inf never overflows before the compare
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inf_q, inf_d;
  logic [ADR_W-1:0] inf_pc_q, inf_pc_d;
  logic             drop_q, drop_d;

  logic [INS_W-1:0] fifo_ins_q [DEPTH];
  logic [ADR_W-1:0] fifo_pc_q  [DEPTH];

  logic             pop_req;
  logic             pop;
  logic             push;
  logic             issue;
  logic [OCC_W-1:0] occ;

  // Head of the FIFO is presented directly to decode
  assign ins_vld = (count_q != '0);
  assign ins     = fifo_ins_q[rd_ptr_q];
  assign ins_pc  = fifo_pc_q[rd_ptr_q];

  // Slots that will be occupied after this edge if we do not issue; a pop in
  // this cycle frees one, which is what sustains one word per cycle.
  assign pop_req = ins_vld & ins_rdy;
  assign occ     = OCC_W'(count_q) + OCC_W'(inf_q) - OCC_W'(pop_req);

  // Issue decision: blocked in reset, during a redirect, and when every slot is
  // already claimed by a queued or in-flight word.
  assign issue  = clr_n & ~redir & (occ < OCC_W'(DEPTH));
  assign im_rd  = issue;
  assign im_adr = pc_q;

  // A redirect voids both the pop and any word returning in the same cycle
  assign push = inf_q & ~drop_q & ~redir;
  assign pop  = pop_req & ~redir;

  // Next-state logic for pc, in-flight tracking and FIFO bookkeeping
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    inf_d    = 1'b0;
    inf_pc_d = inf_pc_q;
    drop_d   = 1'b0;

    if (redir) begin
      pc_d     = redir_adr;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      // An outstanding read would return next cycle; mark it for discard
      drop_d   = inf_q;
    end else begin
      if (issue) begin
        pc_d     = pc_q + ADR_W'(1);
        inf_d    = 1'b1;
        inf_pc_d = pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      inf_q    <= 1'b0;
      inf_pc_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      inf_q    <= inf_d;
      inf_pc_q <= inf_pc_d;
      drop_q   <= drop_d;
    end
  end

  // FIFO storage; cleared on reset so the head outputs read zero
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      fifo_ins_q <= '{default: '0};
      fifo_pc_q  <= '{default: '0};
    end else if (push) begin
      fifo_ins_q[wr_ptr_q] <= im_data;
      fifo_pc_q[wr_ptr_q]  <= inf_pc_q;
    end
  end

endmodule

// File: tb/tb_nr_fetch_unit.sv
// Bench for nr_fetch_unit: directed scenarios plus a randomized phase, checked
// every cycle against a queue-based model of the fetch stage, with literal
// expectations on the accepted-word stream for the directed scenarios.
module tb_nr_fetch_unit;

  logic       clk;
  logic       clr_n;
  logic       im_rd;
  logic [7:0] im_adr;
  logic [7:0] im_data;
  logic       redir;
  logic [7:0] redir_adr;
  logic       ins_vld;
  logic [7:0] ins;
  logic [7:0] ins_pc;
  logic       ins_rdy;

  nr_fetch_unit #(.DEPTH(4), .ADR_W(8), .INS_W(8)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .im_rd     (im_rd),
    .im_adr    (im_adr),
    .im_data   (im_data),
    .redir     (redir),
    .redir_adr (redir_adr),
    .ins_vld   (ins_vld),
    .ins       (ins),
    .ins_pc    (ins_pc),
    .ins_rdy   (ins_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: data one cycle after the request, garbage otherwise
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (im_rd) im_data <= mem[im_adr];
    else       im_data <= 8'($urandom);
  end

  int n_vec;
  int n_miss;

  // Reference model state
  int         m_pc;
  bit         m_inf;
  int         m_inf_pc;
  logic [7:0] m_inf_dat;
  bit         m_drop;
  int         mq_pc[$];
  logic [7:0] mq_dat[$];

  // Observation logs of the DUT
  int         pops_pc[$];
  int         pops_dat[$];
  int         vld_log[$];
  int         rd_log[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned lget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_inf = 0; m_inf_pc = 0; m_inf_dat = '0; m_drop = 0;
    mq_pc.delete(); mq_dat.delete();
  endtask

  task automatic clear_logs();
    pops_pc.delete(); pops_dat.delete(); vld_log.delete(); rd_log.delete();
  endtask

  // Compare all outputs against the model for the current cycle
  task automatic compare_now();
    bit exp_rd;
    int occ;
    if (!clr_n) begin
      model_reset();
      check("rst_im_rd", 32'(im_rd), 0);
      check("rst_im_adr", 32'(im_adr), 0);
      check("rst_ins_vld", 32'(ins_vld), 0);
      check("rst_ins", 32'(ins), 0);
      check("rst_ins_pc", 32'(ins_pc), 0);
    end else begin
      occ = mq_pc.size() + int'(m_inf) - (((mq_pc.size() > 0) && ins_rdy) ? 1 : 0);
      exp_rd = !redir && (occ < 4);
      check("im_rd", 32'(im_rd), 32'(exp_rd));
      if (exp_rd) check("im_adr", 32'(im_adr), 32'(m_pc));
      check("ins_vld", 32'(ins_vld), 32'(mq_pc.size() > 0));
      if (mq_pc.size() > 0) begin
        check("ins_pc", 32'(ins_pc), 32'(mq_pc[0]));
        check("ins", 32'(ins), 32'(mq_dat[0]));
      end
    end
  endtask

  // Advance the model across one rising edge
  task automatic model_step(input bit r, input int ra, input bit rdy);
    bit pop_m;
    bit iss;
    if (!clr_n) begin
      model_reset();
      return;
    end
    pop_m = (mq_pc.size() > 0) && rdy && !r;
    iss = !r && ((mq_pc.size() + int'(m_inf) - (((mq_pc.size() > 0) && rdy) ? 1 : 0)) < 4);
    if (r) begin
      mq_pc.delete(); mq_dat.delete();
      m_drop = m_inf;
      m_inf = 0;
      m_pc = ra;
    end else begin
      if (pop_m) begin
        void'(mq_pc.pop_front());
        void'(mq_dat.pop_front());
      end
      if (m_inf && !m_drop) begin
        mq_pc.push_back(m_inf_pc);
        mq_dat.push_back(m_inf_dat);
      end
      if (iss) begin
        m_inf = 1;
        m_inf_pc = m_pc;
        m_inf_dat = mem[m_pc];
        m_pc = (m_pc + 1) % 256;
      end else begin
        m_inf = 0;
      end
      m_drop = 0;
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, step the model
  task automatic cycle(input bit r, input int ra, input bit rdy);
    redir = r;
    redir_adr = 8'(ra);
    ins_rdy = rdy;
    @(negedge clk);
    compare_now();
    vld_log.push_back(int'(ins_vld));
    rd_log.push_back(int'(im_rd));
    if (clr_n && ins_vld && ins_rdy && !redir) begin
      pops_pc.push_back(int'(ins_pc));
      pops_dat.push_back(int'(ins));
    end
    @(posedge clk);
    model_step(r, ra, rdy);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    clr_n = 1'b0;
    redir = 1'b0;
    redir_adr = '0;
    ins_rdy = 1'b0;
    model_reset();

    // Reset
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);

    // Straight-line fetch
    clr_n = 1'b1;
    clear_logs();
    for (int i = 0; i < 8; i++) cycle(0, 0, 1);
    check("first_rd", 32'(lget(rd_log, 0)), 1);
    check("lat_vld0", 32'(lget(vld_log, 1)), 0);
    check("lat_vld1", 32'(lget(vld_log, 2)), 1);
    check("sl_pops", 32'(pops_pc.size()), 6);
    check("sl_pc0", lget(pops_pc, 0), 32'h00);
    check("sl_pc2", lget(pops_pc, 2), 32'h02);
    check("sl_ins0", lget(pops_dat, 0), 32'hA5);
    check("sl_ins1", lget(pops_dat, 1), 32'hA4);
    check("sl_ins2", lget(pops_dat, 2), 32'hA7);

    // Backpressure: fill, then drain in order and resume without gaps
    clear_logs();
    cycle(1, 8'h00, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    check("bp_full_rd", 32'(lget(rd_log, 10)), 0);
    check("bp_full_vld", 32'(lget(vld_log, 10)), 1);
    clear_logs();
    for (int i = 0; i < 10; i++) cycle(0, 0, 1);
    check("bp_pops", 32'(pops_pc.size()), 10);
    for (int i = 0; i < 8; i++) check("bp_seq", lget(pops_pc, i), 32'(i));

    // Address wrap
    clear_logs();
    cycle(1, 8'hFE, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1);
    check("wr_pc0", lget(pops_pc, 0), 32'hFE);
    check("wr_pc1", lget(pops_pc, 1), 32'hFF);
    check("wr_pc2", lget(pops_pc, 2), 32'h00);
    check("wr_pc3", lget(pops_pc, 3), 32'h01);
    check("wr_ins0", lget(pops_dat, 0), 32'h5B);

    // Redirect with two queued words and one read in flight
    cycle(1, 8'h10, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    clear_logs();
    cycle(1, 8'h40, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1);
    check("ri_vld_r", 32'(lget(vld_log, 0)), 1);
    check("ri_vld_r1", 32'(lget(vld_log, 1)), 0);
    check("ri_vld_r2", 32'(lget(vld_log, 2)), 0);
    check("ri_vld_r3", 32'(lget(vld_log, 3)), 1);
    check("ri_pc0", lget(pops_pc, 0), 32'h40);
    check("ri_ins0", lget(pops_dat, 0), 32'hE5);

    // Redirect together with a pop, then back-to-back redirects
    clear_logs();
    cycle(1, 8'h10, 1);
    cycle(1, 8'h20, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1);
    check("bb_vld_r", 32'(lget(vld_log, 0)), 1);
    check("bb_pops", 32'(pops_pc.size()), 3);
    check("bb_pc0", lget(pops_pc, 0), 32'h20);
    check("bb_pc1", lget(pops_pc, 1), 32'h21);

    // Asynchronous reset between edges with the FIFO full
    for (int i = 0; i < 8; i++) cycle(0, 0, 0);
    check("ar_pre_vld", 32'(ins_vld), 1);
    #2;
    clr_n = 1'b0;
    #1;
    check("ar_vld", 32'(ins_vld), 0);
    check("ar_rd", 32'(im_rd), 0);
    check("ar_count", 32'(dut.count_q), 0);
    model_reset();
    for (int i = 0; i < 2; i++) cycle(0, 0, 1);
    clr_n = 1'b1;
    clear_logs();
    for (int i = 0; i < 4; i++) cycle(0, 0, 1);
    check("ar_pc0", lget(pops_pc, 0), 32'h00);
    check("ar_ins0", lget(pops_dat, 0), 32'hA5);

    // Randomized phase with fresh memory contents
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        clr_n = 1'b0;
        cycle(0, 0, 1);
        clr_n = 1'b1;
      end else begin
        cycle(($urandom_range(0, 19) == 0), int'($urandom_range(0, 255)),
              ($urandom_range(0, 9) < 6));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/nr_fetch_unit.md
# nr_fetch_unit

Instruction fetch stage sitting between the program counter logic and the decoder. It drives read requests into the 256×8 instruction memory, captures the returned words into a small prefetch FIFO tagged with their addresses, and hands them to decode over a valid/ready handshake. Branch/jump redirects flush all queued and in-flight words and restart fetch at the new address.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `ADR_W`, 8: instruction address width; the PC wraps modulo 2^ADR_W.
- `INS_W`, 8: instruction word width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `clr_n`  in  1  asynchronous active-low reset. Assertion takes effect immediately; release is synchronised by the system.
- `im_rd`  out  1  instruction memory read request, one word per cycle.
- `im_adr`  out  ADR_W  read address; valid when `im_rd`=1.
- `im_data`  in  INS_W  memory read data; valid exactly one cycle after the cycle in which `im_rd`=1.
- `redir`  in  1  redirect strobe, one cycle wide (taken branch/jump).
- `redir_adr`  in  ADR_W  redirect target; sampled when `redir`=1.
- `ins_vld`  out  1  the FIFO head holds a valid instruction.
- `ins`  out  INS_W  FIFO head instruction word.
- `ins_pc`  out  ADR_W  address the head word was fetched from.
- `ins_rdy`  in  1  decode accepts the head; a pop occurs on `ins_vld & ins_rdy`.

## Operation
- State: `pc`, FIFO (data+pc per entry, read/write pointers, `count`), in-flight flag `inf` plus its address tag `inf_pc`, and `drop` (discard flag).
- Issue rule: `im_rd` = `clr_n` & !`redir` & (`count` + `inf` − pop < `DEPTH`). This is combinational on the current state and `ins_rdy`. When issuing, `im_adr`=`pc`, and at the edge `pc`←`pc`+1 (255→0 wrap, no flag), `inf`←1, `inf_pc`←`pc`. Otherwise `inf`←0.
- Capture: in a cycle with `inf`=1 and `drop`=0, `im_data` and `inf_pc` are pushed at the edge.
- Pop: on `ins_vld & ins_rdy`, the head advances. Push and pop in the same cycle are both performed and `count` is unchanged.
- FIFO full (`count`=`DEPTH`): no issue. Push never overflows because of the issue rule. FIFO empty: `ins_vld`=0, and `ins`/`ins_pc` hold their last values (don't-care).
- Redirect (`redir`=1) has priority over everything else:
  - At the edge: `count`←0, pointers reset, `pc`←`redir_adr`, `inf`←0.
  - A pop requested in the same cycle is void; decode must treat its head as discarded.
  - A word returning in the redirect cycle is not pushed.
  - No issue in the redirect cycle. A redirect in consecutive cycles: the last one wins.
- `drop` covers a redirect that lands while a request is outstanding. It is set at the edge when `redir`=1 and `inf`=1, and cleared at the next edge. Because issue is blocked during `redir`, the data discarded is always the pre-redirect word.
- Pointer arithmetic is modulo `DEPTH`. `count` is log2(`DEPTH`)+1 bits wide.

## Timing
- Reset values (asynchronous): `pc`=0, `count`=0, pointers=0, `inf`=0, `drop`=0. Outputs during reset: `im_rd`=0, `im_adr`=0, `ins_vld`=0, `ins`=0, `ins_pc`=0.
- First issue: the first cycle after `clr_n` rises, `im_rd`=1 with `im_adr`=0.
- Fetch latency: issue in cycle k → push at the end of cycle k+1 → `ins_vld`=1 in cycle k+2.
- Throughput with `ins_rdy` held at 1: one instruction per cycle, sustained. Steady state is `count`≤1 with `inf`=1.
- Redirect in cycle r: the first issue at `redir_adr` is in cycle r+1, and `ins_vld`=1 with `ins_pc`=`redir_adr` in cycle r+3. `ins_vld`=0 in cycles r+1 and r+2.
- Reset mid-operation: all state clears immediately, and any returning `im_data` is ignored.

## Test plan
- Straight-line: reset release, `ins_rdy`=1, memory[i]=i^8'hA5 → `ins_vld` rises 2 cycles after the first issue; `ins_pc`=0,1,2,…; `ins`=A5,A4,A7,…; one word per cycle with no bubbles.
- Backpressure: `ins_rdy`=0 for 10 cycles → exactly `DEPTH` (4) words queued, `im_rd`=0 while full; raising `ins_rdy` drains `ins_pc`=0..3 in order, then fetch resumes at 4 with no gaps or duplicates.
- Wrap: `redir_adr`=8'hFE, then run → `ins_pc` sequence FE, FF, 00, 01.
- Redirect with an in-flight read: redirect to 8'h40 while `inf`=1 and 2 words are queued → queued and in-flight words are never presented; the next valid word has `ins_pc`=40, 3 cycles after `redir`.
- Redirect together with a pop, and back-to-back redirects to 10 then 20 → the popped head is discarded; the first valid `ins_pc`=20; no word from address 10 appears.
- Async reset mid-stream: `clr_n` pulled low between clock edges with FIFO full → `ins_vld`, `im_rd`, and `count` are 0 immediately; after release, fetch restarts at `ins_pc`=0.
